// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcode/funct
// constants, ALU operation codes and datapath mux selects.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (adds the HALT trap state).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StRwb    = 4'd8,
        StIExec  = 4'd9,
        StIwb    = 4'd10,
        StBranch = 4'd11,
        StJump   = 4'd12
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        StHalt   = 4'd13
`endif
    } state_e;

    // Opcode and function fields
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADDU = 2'b00;
    localparam logic [1:0] ALUOP_SUBU = 2'b01;

    // Datapath mux selects
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic       SRC_A_PC      = 1'b0;
    localparam logic       SRC_A_REG     = 1'b1;
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    // True for the supported instruction set; everything else is undefined.
    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE:                            return (funct == FUNCT_ADDU) ||
                                                        (funct == FUNCT_SUBU);
            OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational state -> control decode for mc_ctrl. Pure Moore decode except
// for the FETCH write enables (qualified by mem_ack) and the BRANCH PC write
// (qualified by zero).
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (HALT drives illegal).
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output ctrl_t      ctrl
);

    // Decode datapath controls from the current state; unlisted outputs stay 0.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALUOP_ADDU;
        case (state)
            StFetch: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_we     = mem_ack;
                ctrl.pc_we     = mem_ack;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut.
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_IMM_SH2;
            end
            StMemAdr: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            StMemRd: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = 1'b1;
            end
            StExec: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = (funct == FUNCT_SUBU) ? ALUOP_SUBU : ALUOP_ADDU;
            end
            StRwb: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
            StIExec: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            StIwb: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b0;
            end
            StBranch: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALUOP_SUBU;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.pc_we     = zero;
            end
            StJump: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = PC_SRC_JUMP;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            StHalt: begin
                ctrl.illegal = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/
// write-back, stalling in place on the memory req/ack handshake.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (undefined instructions trap
// into HALT instead of executing as NOP).
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    // Next-state logic; mem_ack only matters in the three waiting states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_ack) state_d = StDecode;
            StDecode: begin
                if (!instr_legal(op, funct)) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StFetch;
`endif
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = StMemAdr;
                        OP_RTYPE:     state_d = StExec;
                        OP_ADDIU:     state_d = StIExec;
                        OP_BEQ:       state_d = StBranch;
                        OP_J:         state_d = StJump;
                        default:      state_d = StFetch;
                    endcase
                end
            end
            StMemAdr: state_d = (op == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ack) state_d = StMemWb;
            StMemWr:  if (mem_ack) state_d = StFetch;
            StExec:   state_d = StRwb;
            StIExec:  state_d = StIwb;
            StMemWb, StRwb, StIwb, StBranch, StJump: state_d = StFetch;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            StHalt:   state_d = StHalt;
`endif
            default:  state_d = StIdle;
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    mc_ctrl_dec u_dec (
        .state   (state_q),
        .funct   (funct),
        .zero    (zero),
        .mem_ack (mem_ack),
        .ctrl    (ctrl)
    );

    assign mem_rd     = ctrl.mem_rd;
    assign mem_wr     = ctrl.mem_wr;
    assign iord       = ctrl.iord;
    assign ir_we      = ctrl.ir_we;
    assign pc_we      = ctrl.pc_we;
    assign pc_src     = ctrl.pc_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_we     = ctrl.reg_we;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed instructions followed by random
// instruction/stall mixes, each checked cycle by cycle against an expected
// per-instruction step list built from the instruction's cycle recipe.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_rd, mem_wr, iord, ir_we, pc_we, alu_src_a;
    logic       reg_we, reg_dst, mem_to_reg, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    mc_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ack;
        logic [19:0] v;
    } step_t;

    step_t q[$];

    logic [19:0] obs;
    assign obs = {mem_rd, mem_wr, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_we, reg_dst, mem_to_reg, illegal, state};

    // Expected output vector in the same field order as obs.
    function automatic logic [19:0] v(input logic [3:0] st, input logic rd, input logic wr,
                                      input logic io, input logic irw, input logic pcw,
                                      input logic [1:0] psrc, input logic a,
                                      input logic [1:0] b, input logic [1:0] aop,
                                      input logic rw, input logic rdst, input logic m2r,
                                      input logic ill);
        return {rd, wr, io, irw, pcw, psrc, a, b, aop, rw, rdst, m2r, ill, st};
    endfunction

    // Instruction class: 0 addu 1 subu 2 addiu 3 lw 4 sw 5 beq 6 j 7 undefined
    function automatic int cls(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000 && f == 6'b100001) return 0;
        if (o == 6'b000000 && f == 6'b100011) return 1;
        if (o == 6'b001001) return 2;
        if (o == 6'b100011) return 3;
        if (o == 6'b101011) return 4;
        if (o == 6'b000100) return 5;
        if (o == 6'b000010) return 6;
        return 7;
    endfunction

    function automatic void push(input logic ack, input logic [19:0] vv);
        q.push_back(step_t'({ack, vv}));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [19:0] o, input logic [19:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Build the expected cycle list for one instruction with fw fetch stalls
    // and mw data-memory stalls.
    task automatic build(input int fw, input int mw);
        int c;
        c = cls(op, funct);
        q.delete();
        for (int i = 0; i < fw; i++)
            push(1'b0, v(StFetch, 1, 0, 0, 0, 0, PC_SRC_ALU, SRC_A_PC, SRC_B_FOUR,
                         ALUOP_ADDU, 0, 0, 0, 0));
        push(1'b1, v(StFetch, 1, 0, 0, 1, 1, PC_SRC_ALU, SRC_A_PC, SRC_B_FOUR,
                     ALUOP_ADDU, 0, 0, 0, 0));
        push(rb(), v(StDecode, 0, 0, 0, 0, 0, 2'b00, SRC_A_PC, SRC_B_IMM_SH2,
                     ALUOP_ADDU, 0, 0, 0, 0));
        case (c)
            0, 1: begin
                push(rb(), v(StExec, 0, 0, 0, 0, 0, 2'b00, SRC_A_REG, SRC_B_REG,
                             (c == 1) ? ALUOP_SUBU : ALUOP_ADDU, 0, 0, 0, 0));
                push(rb(), v(StRwb, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, ALUOP_ADDU, 1, 1, 0, 0));
            end
            2: begin
                push(rb(), v(StIExec, 0, 0, 0, 0, 0, 2'b00, SRC_A_REG, SRC_B_IMM,
                             ALUOP_ADDU, 0, 0, 0, 0));
                push(rb(), v(StIwb, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, ALUOP_ADDU, 1, 0, 0, 0));
            end
            3, 4: begin
                push(rb(), v(StMemAdr, 0, 0, 0, 0, 0, 2'b00, SRC_A_REG, SRC_B_IMM,
                             ALUOP_ADDU, 0, 0, 0, 0));
                for (int i = 0; i <= mw; i++)
                    push((i == mw), (c == 3)
                         ? v(StMemRd, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, ALUOP_ADDU, 0, 0, 0, 0)
                         : v(StMemWr, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, ALUOP_ADDU, 0, 0, 0, 0));
                if (c == 3)
                    push(rb(), v(StMemWb, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, ALUOP_ADDU,
                                 1, 0, 1, 0));
            end
            5: push(rb(), v(StBranch, 0, 0, 0, 0, zero, PC_SRC_ALUOUT, SRC_A_REG, SRC_B_REG,
                            ALUOP_SUBU, 0, 0, 0, 0));
            6: push(rb(), v(StJump, 0, 0, 0, 0, 1, PC_SRC_JUMP, 0, 2'b00, ALUOP_ADDU,
                            0, 0, 0, 0));
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++)
                    push(rb(), v(StHalt, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, ALUOP_ADDU,
                                 0, 0, 0, 1));
`endif
            end
        endcase
    endtask

    // Drive and check each expected cycle; returns just after a rising edge.
    task automatic run(input string tag);
        foreach (q[i]) begin
            mem_ack = q[i].ack;
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), obs, q[i].v);
            @(posedge clk);
            #1;
        end
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, then release.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_async"}, obs, 20'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_idle"}, obs, 20'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fw, input int mw, input string tag);
        op = o;
        funct = f;
        zero = z;
        build(fw, mw);
        run(tag);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (cls(o, f) == 7) apply_reset({tag, "_halt"});
`endif
    endtask

    initial begin
        logic [5:0] bad_ops [4];
        logic [5:0] good_ops [6];
        bad_ops  = '{6'b111111, 6'b000001, 6'b001000, 6'b100000};
        good_ops = '{OP_RTYPE, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J};

        #2;
        check("reset", obs, 20'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle", obs, 20'h0);
        @(posedge clk);
        #1;

        instr(OP_RTYPE, FUNCT_ADDU, 1'b0, 0, 0, "addu");
        instr(OP_LW, 6'h15, 1'b0, 0, 2, "lw_wait2");
        instr(OP_BEQ, 6'h00, 1'b1, 0, 0, "beq_taken");
        instr(OP_BEQ, 6'h00, 1'b0, 0, 0, "beq_not");
        instr(OP_RTYPE, FUNCT_SUBU, 1'b0, 1, 0, "subu");
        instr(OP_SW, 6'h07, 1'b0, 0, 0, "sw");
        instr(OP_J, 6'h00, 1'b1, 0, 0, "j");
        instr(OP_ADDIU, 6'h3f, 1'b0, 2, 0, "addiu");
        instr(6'b111111, 6'h00, 1'b0, 0, 0, "op3f");
        instr(OP_RTYPE, 6'b100000, 1'b0, 0, 0, "bad_funct");

        // Abort a store while it is stalled in MEMWR.
        op = OP_SW;
        funct = 6'h00;
        build(0, 3);
        void'(q.pop_back());
        void'(q.pop_back());
        run("sw_abort");
        #2;
        apply_reset("sw_abort_rst");

        for (int n = 0; n < 150; n++) begin
            logic [5:0] o, f;
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 7) begin
                o = good_ops[$urandom_range(0, 5)];
                f = ($urandom_range(0, 1) == 1) ? FUNCT_ADDU : FUNCT_SUBU;
            end else if (pick == 7) begin
                o = bad_ops[$urandom_range(0, 3)];
                f = 6'($urandom);
            end else begin
                o = OP_RTYPE;
                f = 6'($urandom);
            end
            instr(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 3),
                  $sformatf("rnd%0d", n));
        end

        instr(OP_RTYPE, FUNCT_ADDU, 1'b0, 0, 0, "final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back cycles, and drives the ALU's 2-bit operation select plus all datapath register enables and multiplexer selects. Sits directly upstream of the ALU and consumes its `zero` flag for branch resolution. Memory accesses use a req/ack handshake, so the controller stalls in place on slow memory.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `op`  in  6  instruction opcode field (IR[31:26]).
- `funct`  in  6  R-type function field (IR[5:0]).
- `zero`  in  1  ALU equality flag, valid in BRANCH.
- `mem_ack`  in  1  memory completes the current read/write this cycle.
- `mem_rd`, `mem_wr`  out  1  memory read / write request, held until `mem_ack`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_we`  out  1  instruction register load.
- `pc_we`  out  1  PC write.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `alu_op`  out  2  `ALUOp_ADDU` / `ALUOp_SUBU`.
- `reg_we`  out  1  register-file write.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `illegal`  out  1  undefined instruction detected (see Configuration).
- `state`  out  4  current state, for debug.

## Operation
- Supported instructions: addu (000000/100001), subu (000000/100011), addiu (001001), lw (100011), sw (101011), beq (000100), j (000010).
- Moore FSM. Outputs decode from the state register. The exceptions are `pc_we` in BRANCH (= `zero`) and the write enables in FETCH (qualified by `mem_ack`).
- Every output not listed for a state is 0. `alu_op` defaults to ADDU.
- States and transitions:
  - IDLE → FETCH.
  - FETCH: `mem_rd`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_src`=00. On `mem_ack`, assert `ir_we` and `pc_we` and go to DECODE; otherwise stay.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11 (branch target into ALUOut). Next state by `op`: lw/sw → MEMADR; R-type → EXEC; addiu → IEXEC; beq → BRANCH; j → JUMP; anything else → undefined handling.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next: lw → MEMRD, sw → MEMWR.
  - MEMRD: `mem_rd`, `iord`=1. Stay until `mem_ack`, then MEMWB.
  - MEMWB: `reg_we`, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
  - MEMWR: `mem_wr`, `iord`=1. Stay until `mem_ack`, then FETCH.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from `funct` → RWB.
  - RWB: `reg_we`, `reg_dst`=1 → FETCH.
  - IEXEC: `alu_src_a`=1, `alu_src_b`=10, ADDU → IWB.
  - IWB: `reg_we`, `reg_dst`=0 → FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, SUBU, `pc_src`=01, `pc_we`=`zero` → FETCH.
  - JUMP: `pc_we`, `pc_src`=10 → FETCH.
- R-type with an unsupported `funct` follows the undefined-instruction handling.
- `mem_rd` and `mem_wr` are never asserted together.
- `mem_ack` is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Reset: state = IDLE and all outputs 0. Asserting `rst_n` mid-instruction aborts it immediately; no partial write is completed after the assert.
- The first FETCH occurs on the second rising edge after `rst_n` deasserts.
- Cycle counts with `mem_ack` high on first request: beq 3, j 3, R-type 4, addiu 4, sw 4, lw 5.
- Each cycle `mem_ack` is held low adds one cycle in the waiting state, with outputs held stable.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An undefined op/funct in DECODE → HALT state.
  - In HALT, `illegal` = 1 and all other outputs are 0; the controller stays there until reset.
- Macro undefined:
  - An undefined op/funct → FETCH; the instruction executes as a NOP.
  - HALT does not exist and `illegal` is tied to 0.

## Structure
- State encodings, opcode/funct constants and mux-select codes go in the shared `ctrl_encode_def.v`, alongside the existing `ALUOp_*` macros.
- One sub-module, `mc_ctrl_dec`: combinational state → output decode. The next-state register stays in `mc_ctrl`.

## Test plan
- addu with `mem_ack` tied high: sequence FETCH, DECODE, EXEC, RWB over 4 cycles; `alu_op`=ADDU in EXEC; `reg_we`=1 and `reg_dst`=1 in RWB only.
- lw with `mem_ack` delayed 2 cycles in MEMRD: 7 cycles total; `mem_rd`=1 and `iord`=1 held stable through the wait; `mem_to_reg`=1 in MEMWB.
- beq: with `zero`=1, `pc_we`=1 and `pc_src`=01 in BRANCH; with `zero`=0, `pc_we`=0. `alu_op`=SUBU in both cases.
- `rst_n` asserted during MEMWR: outputs go to 0 asynchronously, `mem_wr` drops, state = IDLE, and FETCH follows 2 edges after release.
- op=111111:
  - With the macro defined: HALT, `illegal`=1, no further `mem_rd`.
  - Without the macro: return to FETCH after DECODE with `illegal`=0.
